// File: rtl/mips_mc_control.sv
// mips_mc_control -- multicycle MIPS control FSM with memory-wait timeout trap
// and a retired-instruction counter.
//
// Parameters:
//   TIMEOUT_MAX  memory wait cycles allowed before trapping (0 = no timeout)
//   CNT_W        width of the retired-instruction counter
// Ports:
//   clk, reset          single clock, synchronous active-high reset
//   OpCode[5:0]         opcode from the instruction register
//   mem_ready           memory completes the current access this cycle
//   PCWrite .. ALUSrcA  single-bit multicycle datapath controls
//   ALUSrcB, ALUOp, PCSource  2-bit datapath selects
//   state[3:0]          current FSM state code
//   trap                FSM is in TRAP (left only by reset)
//   instr_done          one-cycle pulse when an instruction retires
//   instr_count         retired-instruction count, wraps modulo 2^CNT_W
// Build option:
//   MC_IMMLOGIC_EN      when defined, andi/ori decode to LOGIEX; otherwise they trap.

module mips_mc_control #(
    parameter int unsigned TIMEOUT_MAX = 15,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       OpCode,
    input  logic             mem_ready,
    output logic             PCWrite,
    output logic             PCWriteCond,
    output logic             PCWriteCondNe,
    output logic             IorD,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             MemToReg,
    output logic             RegDst,
    output logic             RegWrite,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ALUOp,
    output logic [1:0]       PCSource,
    output logic [3:0]       state,
    output logic             trap,
    output logic             instr_done,
    output logic [CNT_W-1:0] instr_count
);

    localparam logic [3:0] S_FETCH  = 4'd0;
    localparam logic [3:0] S_DECODE = 4'd1;
    localparam logic [3:0] S_MEMADR = 4'd2;
    localparam logic [3:0] S_MEMRD  = 4'd3;
    localparam logic [3:0] S_MEMWB  = 4'd4;
    localparam logic [3:0] S_MEMWR  = 4'd5;
    localparam logic [3:0] S_EXEC   = 4'd6;
    localparam logic [3:0] S_ALUWB  = 4'd7;
    localparam logic [3:0] S_BEQ    = 4'd8;
    localparam logic [3:0] S_ADDIEX = 4'd9;
    localparam logic [3:0] S_IMMWB  = 4'd10;
    localparam logic [3:0] S_JUMP   = 4'd11;
    localparam logic [3:0] S_BNE    = 4'd12;
    localparam logic [3:0] S_LOGIEX = 4'd13;
    localparam logic [3:0] S_TRAP   = 4'd15;

    // Wide enough to hold TIMEOUT_MAX without wrapping before the compare.
    localparam int unsigned        WAIT_W   = $clog2(TIMEOUT_MAX + 2);
    localparam logic [WAIT_W-1:0]  WAIT_LIM = WAIT_W'(TIMEOUT_MAX);

    logic [3:0]        state_q;
    logic [3:0]        state_nxt;
    logic [WAIT_W-1:0] wait_cnt;
    logic [WAIT_W-1:0] wait_inc;
    logic              mem_wait;
    logic              timeout;
    logic              retire;

    assign state = state_q;
    assign trap  = (state_q == S_TRAP);

    always_comb begin
        mem_wait = ((state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR))
                   && !mem_ready;
        wait_inc = wait_cnt + 1'b1;
        // mem_ready=1 never times out: mem_wait already excludes it.
        timeout  = (TIMEOUT_MAX != 0) && mem_wait && (wait_inc == WAIT_LIM);
    end

    always_comb begin
        state_nxt = S_TRAP;
        case (state_q)
            S_FETCH:  state_nxt = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (OpCode)
                    6'b000000:            state_nxt = S_EXEC;
                    6'b100011, 6'b101011: state_nxt = S_MEMADR;
                    6'b000100:            state_nxt = S_BEQ;
                    6'b000101:            state_nxt = S_BNE;
                    6'b001000:            state_nxt = S_ADDIEX;
                    6'b000010:            state_nxt = S_JUMP;
`ifdef MC_IMMLOGIC_EN
                    6'b001100, 6'b001101: state_nxt = S_LOGIEX;
`else
                    6'b001100, 6'b001101: state_nxt = S_TRAP;
`endif
                    default:              state_nxt = S_TRAP;
                endcase
            end
            // sw (101011) is the only store reaching here; bit 3 separates it from lw.
            S_MEMADR: state_nxt = OpCode[3] ? S_MEMWR : S_MEMRD;
            S_MEMRD:  state_nxt = mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWB:  state_nxt = S_FETCH;
            S_MEMWR:  state_nxt = mem_ready ? S_FETCH : S_MEMWR;
            S_EXEC:   state_nxt = S_ALUWB;
            S_ALUWB:  state_nxt = S_FETCH;
            S_BEQ:    state_nxt = S_FETCH;
            S_BNE:    state_nxt = S_FETCH;
            S_ADDIEX: state_nxt = S_IMMWB;
            S_LOGIEX: state_nxt = S_IMMWB;
            S_IMMWB:  state_nxt = S_FETCH;
            S_JUMP:   state_nxt = S_FETCH;
            default:  state_nxt = S_TRAP;
        endcase
        if (timeout) begin
            state_nxt = S_TRAP;
        end
    end

    always_comb begin
        retire = 1'b0;
        if (state_nxt == S_FETCH) begin
            case (state_q)
                S_MEMWB, S_MEMWR, S_ALUWB, S_BEQ,
                S_BNE, S_IMMWB, S_JUMP: retire = 1'b1;
                default:                retire = 1'b0;
            endcase
        end
        instr_done = retire && !reset;
    end

    always_comb begin
        PCWrite       = 1'b0;
        PCWriteCond   = 1'b0;
        PCWriteCondNe = 1'b0;
        IorD          = 1'b0;
        MemRead       = 1'b0;
        MemWrite      = 1'b0;
        IRWrite       = 1'b0;
        MemToReg      = 1'b0;
        RegDst        = 1'b0;
        RegWrite      = 1'b0;
        ALUSrcA       = 1'b0;
        ALUSrcB       = 2'b00;
        ALUOp         = 2'b00;
        PCSource      = 2'b00;
        case (state_q)
            S_FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                IRWrite = mem_ready;
                PCWrite = mem_ready;
            end
            S_DECODE: ALUSrcB = 2'b11;
            S_MEMADR, S_ADDIEX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            S_LOGIEX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                ALUOp   = 2'b11;
            end
            S_MEMRD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
            end
            S_MEMWB: begin
                RegWrite = 1'b1;
                MemToReg = 1'b1;
            end
            S_MEMWR: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
            end
            S_EXEC: begin
                ALUSrcA = 1'b1;
                ALUOp   = 2'b10;
            end
            S_ALUWB: begin
                RegWrite = 1'b1;
                RegDst   = 1'b1;
            end
            S_BEQ: begin
                ALUSrcA     = 1'b1;
                ALUOp       = 2'b01;
                PCSource    = 2'b01;
                PCWriteCond = 1'b1;
            end
            S_BNE: begin
                ALUSrcA       = 1'b1;
                ALUOp         = 2'b01;
                PCSource      = 2'b01;
                PCWriteCondNe = 1'b1;
            end
            S_IMMWB: RegWrite = 1'b1;
            S_JUMP: begin
                PCWrite  = 1'b1;
                PCSource = 2'b10;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_FETCH;
            wait_cnt    <= '0;
            instr_count <= '0;
        end else begin
            state_q <= state_nxt;
            // Clearing on every state change covers each entry into a memory state.
            if (state_nxt != state_q) begin
                wait_cnt <= '0;
            end else if (mem_wait) begin
                wait_cnt <= wait_inc;
            end
            if (retire) begin
                instr_count <= instr_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mips_mc_control.sv
module tb_mips_mc_control;

    localparam int TMO = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] OpCode;
    logic       mem_ready;
    logic       PCWrite, PCWriteCond, PCWriteCondNe, IorD, MemRead, MemWrite;
    logic       IRWrite, MemToReg, RegDst, RegWrite, ALUSrcA;
    logic [1:0] ALUSrcB, ALUOp, PCSource;
    logic [3:0] state;
    logic       trap, instr_done;
    logic [3:0] instr_count;

    mips_mc_control #(.TIMEOUT_MAX(TMO), .CNT_W(4)) dut (
        .clk(clk), .reset(reset), .OpCode(OpCode), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .PCWriteCondNe(PCWriteCondNe),
        .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .MemToReg(MemToReg), .RegDst(RegDst), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSource(PCSource), .state(state),
        .trap(trap), .instr_done(instr_done), .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic pcw, pcwc, pcwcne, iord, mrd, mwr, irw, m2r, rdst, rw, asa;
        logic [1:0] asb, aop, pcs;
        logic trap, done;
    } ctrl_t;

    typedef struct {
        bit         chk;
        logic [3:0] st;
        ctrl_t      c;
        logic [3:0] cnt;
    } exp_t;

    exp_t        sb[$];
    exp_t        e_mon;
    ctrl_t       got_c;
    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    int          m_cnt    = 0;
    int          cyc_no   = 0;

    assign got_c = '{pcw: PCWrite, pcwc: PCWriteCond, pcwcne: PCWriteCondNe, iord: IorD,
                     mrd: MemRead, mwr: MemWrite, irw: IRWrite, m2r: MemToReg,
                     rdst: RegDst, rw: RegWrite, asa: ALUSrcA, asb: ALUSrcB,
                     aop: ALUOp, pcs: PCSource, trap: trap, done: instr_done};

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, cyc_no, got, exp);
    endtask

    // Expected datapath controls for a given state and mem_ready.
    function automatic ctrl_t ctrl_for(input int st, input logic mr, input logic done);
        ctrl_t c = '0;
        case (st)
            0:  begin c.mrd = 1; c.asb = 2'b01; c.irw = mr; c.pcw = mr; end
            1:  c.asb = 2'b11;
            2:  begin c.asa = 1; c.asb = 2'b10; end
            3:  begin c.mrd = 1; c.iord = 1; end
            4:  begin c.rw = 1; c.m2r = 1; end
            5:  begin c.mwr = 1; c.iord = 1; end
            6:  begin c.asa = 1; c.aop = 2'b10; end
            7:  begin c.rw = 1; c.rdst = 1; end
            8:  begin c.asa = 1; c.aop = 2'b01; c.pcs = 2'b01; c.pcwc = 1; end
            9:  begin c.asa = 1; c.asb = 2'b10; end
            10: c.rw = 1;
            11: begin c.pcw = 1; c.pcs = 2'b10; end
            12: begin c.asa = 1; c.aop = 2'b01; c.pcs = 2'b01; c.pcwcne = 1; end
            13: begin c.asa = 1; c.asb = 2'b10; c.aop = 2'b11; end
            15: c.trap = 1;
            default: ;
        endcase
        c.done = done;
        return c;
    endfunction

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    // Monitor: pops one expectation per cycle, mid-cycle.
    always @(negedge clk) begin
        cyc_no++;
        if (sb.size() > 0) begin
            e_mon = sb.pop_front();
            if (e_mon.chk) begin
                check("state", 32'(state), 32'(e_mon.st));
                check("ctrl", 32'(got_c), 32'(e_mon.c));
                check("instr_count", 32'(instr_count), 32'(e_mon.cnt));
            end
        end
    end

    // One checked cycle: drive mem_ready, queue the expectation, advance.
    task automatic cyc(input int st, input logic mr, input logic done);
        exp_t e;
        mem_ready = mr;
        e.chk = 1'b1;
        e.st  = 4'(st);
        e.c   = ctrl_for(st, mr, done);
        e.cnt = 4'(m_cnt);
        sb.push_back(e);
        @(posedge clk); #1;
        if (done) m_cnt = (m_cnt + 1) % 16;
    endtask

    task automatic do_reset();
        exp_t e;
        reset     = 1'b1;
        mem_ready = rbit();
        e.chk = 1'b0;
        e.st  = '0;
        e.c   = '0;
        e.cnt = '0;
        sb.push_back(e);
        @(posedge clk); #1;
        reset = 1'b0;
        m_cnt = 0;
    endtask

    // Memory state: ready after lat waiting cycles, or trap once TMO waits pile up.
    task automatic mem_phase(input int st, input int lat, output bit ok);
        ok = 1'b0;
        for (int k = 0; k <= lat; k++) begin
            if (k == lat) begin
                cyc(st, 1'b1, st == 5);
                ok = 1'b1;
                return;
            end
            cyc(st, 1'b0, 1'b0);
            if (k + 1 == TMO) return;
        end
    endtask

    task automatic trap_then_reset();
        repeat (3) cyc(15, rbit(), 1'b0);
        do_reset();
    endtask

    task automatic run_instr(input logic [5:0] op, input int lf, input int lm);
        bit ok;
        OpCode = op;
        mem_phase(0, lf, ok);
        if (!ok) begin trap_then_reset(); return; end
        cyc(1, rbit(), 1'b0);
        case (op)
            6'b000000: begin cyc(6, rbit(), 1'b0); cyc(7, rbit(), 1'b1); end
            6'b100011: begin
                cyc(2, rbit(), 1'b0);
                mem_phase(3, lm, ok);
                if (ok) cyc(4, rbit(), 1'b1);
                else trap_then_reset();
            end
            6'b101011: begin
                cyc(2, rbit(), 1'b0);
                mem_phase(5, lm, ok);
                if (!ok) trap_then_reset();
            end
            6'b000100: cyc(8, rbit(), 1'b1);
            6'b000101: cyc(12, rbit(), 1'b1);
            6'b001000: begin cyc(9, rbit(), 1'b0); cyc(10, rbit(), 1'b1); end
            6'b000010: cyc(11, rbit(), 1'b1);
`ifdef MC_IMMLOGIC_EN
            6'b001100, 6'b001101: begin cyc(13, rbit(), 1'b0); cyc(10, rbit(), 1'b1); end
`else
            6'b001100, 6'b001101: trap_then_reset();
`endif
            default: trap_then_reset();
        endcase
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

    initial begin
        logic [5:0] ops [10];
        bit ok;
        int idx, lf, lm;
        ops = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000101,
                6'b001000, 6'b000010, 6'b001100, 6'b001101, 6'b111111};
        reset = 1'b1;
        mem_ready = 1'b0;
        OpCode = '0;
        @(posedge clk); #1;
        do_reset();

        run_instr(6'b000000, 0, 0);     // R-type: 0,1,6,7,0
        run_instr(6'b100011, 0, 3);     // lw, MEMRD held 4 cycles
        run_instr(6'b101011, 1, 2);     // sw
        run_instr(6'b000101, 0, 0);     // bne
        run_instr(6'b000100, 0, 0);     // beq
        run_instr(6'b001000, 3, 0);     // addi, fetch ready on last allowed cycle
        run_instr(6'b001101, 0, 0);     // ori
        run_instr(6'b000000, 4, 0);     // fetch timeout -> TRAP
        run_instr(6'b100011, 0, 4);     // MEMRD timeout -> TRAP

        // Reset in the middle of a memory wait.
        OpCode = 6'b100011;
        mem_phase(0, 0, ok);
        cyc(1, 1'b1, 1'b0);
        cyc(2, 1'b1, 1'b0);
        cyc(3, 1'b0, 1'b0);
        cyc(3, 1'b0, 1'b0);
        do_reset();

        repeat (17) run_instr(6'b000010, 0, 0);   // counter wraps 15 -> 0

        repeat (150) begin
            idx = $urandom_range(0, 9);
            lf  = ($urandom_range(0, 9) == 0) ? 4 : $urandom_range(0, 3);
            lm  = ($urandom_range(0, 9) == 0) ? 4 : $urandom_range(0, 3);
            run_instr((idx == 9) ? 6'($urandom_range(0, 63)) : ops[idx], lf, lm);
        end

        @(negedge clk); #1;
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
